// File: rtl/core_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : core_bus_arbiter
// Description : Merges the core's data-bus master (m0) and instruction-bus
//               master (m1) onto one slave port. Both sides use a split
//               request/response valid-ready handshake. Only one transaction
//               is in flight at a time. m0 has fixed priority; a starvation
//               counter forces an m1 grant after STARVE_LIMIT consecutive m0
//               grants issued while m1 was waiting.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   m0_* (dbus master side)    addr/data/sel/we request fields, req valid/ready,
//                              rsp valid/ready, read data out
//   m1_* (ibus master side)    same set of signals as m0
//   s_*  (slave side)          muxed request fields, req valid/ready,
//                              rsp valid/ready, read data in
// Parameters
//   STARVE_LIMIT  m0 grants tolerated while m1 waits (0 = pure fixed priority)
//   CNT_W         starvation counter width; STARVE_LIMIT must be < 2**CNT_W
// ============================================================================
module core_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst_n,

    // m0: data bus master
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    output logic [31:0] m0_data_o,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_req_valid_i,
    output logic        m0_req_ready_o,
    output logic        m0_rsp_valid_o,
    input  logic        m0_rsp_ready_i,

    // m1: instruction bus master
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    output logic [31:0] m1_data_o,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_req_valid_i,
    output logic        m1_req_ready_o,
    output logic        m1_rsp_valid_o,
    input  logic        m1_rsp_ready_i,

    // slave port toward memory / interconnect
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    input  logic [31:0] s_data_i,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_req_valid_o,
    input  logic        s_req_ready_i,
    input  logic        s_rsp_valid_i,
    output logic        s_rsp_ready_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [CNT_W-1:0] c_STARVE_LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic             c_STARVE_EN    = (STARVE_LIMIT != 0);
    localparam logic             c_GRANT_M0     = 1'b0;
    localparam logic             c_GRANT_M1     = 1'b1;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,   // arbitrating, request path open
        WAIT_RSP = 1'b1    // one request accepted, awaiting the response
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_next;
    logic               r_grant;
    logic               w_grant_next;
    logic [CNT_W-1:0]   r_starve_cnt;
    logic [CNT_W-1:0]   w_starve_cnt_next;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic               w_sel_m1;       // IDLE arbitration result
    logic               w_route_m1;     // which master's request fields reach s_*
    logic               w_req_valid;
    logic               w_req_fire;
    logic               w_m0_req_ready;
    logic               w_m1_req_ready;
    logic               w_rsp_ready;
    logic               w_m0_rsp_valid;
    logic               w_m1_rsp_valid;

    // m1 wins when m0 is idle, or when m0 has been granted STARVE_LIMIT
    // times in a row while m1 was waiting.
    assign w_sel_m1 = m1_req_valid_i &&
                      (!m0_req_valid_i ||
                       (c_STARVE_EN && (r_starve_cnt == c_STARVE_LIMIT)));

    always_comb begin
        w_state_next      = r_state;
        w_grant_next      = r_grant;
        w_starve_cnt_next = r_starve_cnt;
        w_route_m1        = r_grant;
        w_req_valid       = 1'b0;
        w_req_fire        = 1'b0;
        w_m0_req_ready    = 1'b0;
        w_m1_req_ready    = 1'b0;
        w_rsp_ready       = 1'b0;
        w_m0_rsp_valid    = 1'b0;
        w_m1_rsp_valid    = 1'b0;

        case (r_state)
            IDLE: begin
                w_route_m1     = w_sel_m1;
                w_req_valid    = w_sel_m1 ? m1_req_valid_i : m0_req_valid_i;
                w_m0_req_ready = !w_sel_m1 && s_req_ready_i;
                w_m1_req_ready =  w_sel_m1 && s_req_ready_i;
                w_req_fire     = w_req_valid && s_req_ready_i;

                if (w_req_fire) begin
                    w_state_next = WAIT_RSP;
                    w_grant_next = w_sel_m1 ? c_GRANT_M1 : c_GRANT_M0;
                    if (w_sel_m1) begin
                        w_starve_cnt_next = '0;
                    end else if (m1_req_valid_i &&
                                 (r_starve_cnt < c_STARVE_LIMIT)) begin
                        // m1 was passed over; count it, saturating at the limit
                        w_starve_cnt_next = r_starve_cnt + CNT_W'(1);
                    end
                end
            end

            WAIT_RSP: begin
                // Request side is closed: no second transaction may overlap.
                w_route_m1     = r_grant;
                w_rsp_ready    = (r_grant == c_GRANT_M1) ? m1_rsp_ready_i
                                                         : m0_rsp_ready_i;
                w_m0_rsp_valid = (r_grant == c_GRANT_M0) && s_rsp_valid_i;
                w_m1_rsp_valid = (r_grant == c_GRANT_M1) && s_rsp_valid_i;

                // Return to IDLE on response fire; re-arbitration happens in
                // the following cycle, never in the response cycle itself.
                if (s_rsp_valid_i && w_rsp_ready) begin
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= c_GRANT_M0;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_grant      <= w_grant_next;
            r_starve_cnt <= w_starve_cnt_next;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Handshake outputs are qualified with rst_n so they drop the moment
    // reset asserts; otherwise the IDLE path would pass s_req_ready_i
    // straight through to a master while reset is held.
    assign s_req_valid_o  = rst_n && w_req_valid;
    assign m0_req_ready_o = rst_n && w_m0_req_ready;
    assign m1_req_ready_o = rst_n && w_m1_req_ready;
    assign s_rsp_ready_o  = rst_n && w_rsp_ready;
    assign m0_rsp_valid_o = rst_n && w_m0_rsp_valid;
    assign m1_rsp_valid_o = rst_n && w_m1_rsp_valid;

    // Request fields follow the arbitration result in IDLE and the granted
    // master in WAIT_RSP (where they are don't-care to the slave).
    assign s_addr_o = w_route_m1 ? m1_addr_i : m0_addr_i;
    assign s_data_o = w_route_m1 ? m1_data_i : m0_data_i;
    assign s_sel_o  = w_route_m1 ? m1_sel_i  : m0_sel_i;
    assign s_we_o   = w_route_m1 ? m1_we_i   : m0_we_i;

    // Read data is broadcast; only rsp_valid says whom it belongs to.
    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;

endmodule

`default_nettype wire
